// File: rtl/mismatch_monitor.sv
// Scoreboard stage behind the delay-and-compare block: masks warm-up, counts samples/mismatches,
// flags a sticky failure on a run of mismatches. MISMATCH_MONITOR_FIRST_IDX_EN enables the first-index register.
module mismatch_monitor #(
   parameter int CNT_W     = 16,
   parameter int WARMUP    = 3,
   parameter int THRESHOLD = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             valid,
   input  logic             equal,
   output logic             active,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic             first_mismatch_vld,
   output logic [CNT_W-1:0] first_mismatch_idx
);

   localparam int               WU_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [WU_W-1:0]  WU_LAST = (WARMUP > 0) ? WU_W'(WARMUP - 1) : '0;
   localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARMUP,
      S_MONITOR,
      S_DONE,
      S_FAIL
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WU_W-1:0]  wu_cnt;
   logic [CNT_W-1:0] consec_cnt;
   logic             clr;
   logic             wu_en;
   logic             smp_en;
   logic             mis_en;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      wu_en     = 1'b0;
      smp_en    = 1'b0;
      mis_en    = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               clr       = 1'b1;
               state_nxt = (WARMUP == 0) ? S_MONITOR : S_WARMUP;
            end
         end
         S_WARMUP: begin
            if (stop)                  state_nxt = S_DONE;
            else if (wu_cnt == WU_LAST) state_nxt = S_MONITOR;
            else                       wu_en     = 1'b1;
         end
         S_MONITOR: begin
            // stop outranks the sample presented in the same cycle
            if (stop) begin
               state_nxt = S_DONE;
            end else if (valid) begin
               smp_en = 1'b1;
               if (!equal) begin
                  mis_en = 1'b1;
                  if (sat_inc(consec_cnt) >= THR) state_nxt = S_FAIL;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they line up with the counters
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         done   <= 1'b0;
         fail   <= 1'b0;
      end else begin
         active <= (state_nxt == S_WARMUP) || (state_nxt == S_MONITOR);
         done   <= (state_nxt == S_DONE);
         fail   <= (state_nxt == S_FAIL);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wu_cnt             <= '0;
         sample_count       <= '0;
         mismatch_count     <= '0;
         consec_cnt         <= '0;
         first_mismatch_vld <= 1'b0;
      end else begin
         if (wu_en) wu_cnt <= wu_cnt + WU_W'(1);
         if (smp_en) begin
            sample_count <= sat_inc(sample_count);
            if (mis_en) begin
               mismatch_count     <= sat_inc(mismatch_count);
               consec_cnt         <= sat_inc(consec_cnt);
               first_mismatch_vld <= 1'b1;
            end else begin
               consec_cnt <= '0;
            end
         end
      end
   end

`ifdef MISMATCH_MONITOR_FIRST_IDX_EN
   // Pre-increment sample_count; saturation of that counter carries over naturally
   always_ff @(posedge clk) begin
      if (rst || clr)                     first_mismatch_idx <= '0;
      else if (mis_en && !first_mismatch_vld) first_mismatch_idx <= sample_count;
   end
`else
   assign first_mismatch_idx = '0;
`endif

endmodule

// File: tb/tb_mismatch_monitor.sv
// Directed bench for mismatch_monitor: three instances (THRESHOLD 1, THRESHOLD 2, CNT_W 4 / THRESHOLD 15)
// share one stimulus stream; each scenario checks the instance it targets.
module tb_mismatch_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, stop, valid, equal;

`ifdef MISMATCH_MONITOR_FIRST_IDX_EN
   localparam bit IDX_EN = 1'b1;
`else
   localparam bit IDX_EN = 1'b0;
`endif

   logic        a_active, a_done, a_fail, a_fmv;
   logic [15:0] a_smp, a_mis, a_idx;
   logic        b_active, b_done, b_fail, b_fmv;
   logic [15:0] b_smp, b_mis, b_idx;
   logic        c_active, c_done, c_fail, c_fmv;
   logic [3:0]  c_smp, c_mis, c_idx;

   mismatch_monitor #(.CNT_W(16), .WARMUP(3), .THRESHOLD(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid), .equal(equal),
      .active(a_active), .done(a_done), .fail(a_fail), .sample_count(a_smp),
      .mismatch_count(a_mis), .first_mismatch_vld(a_fmv), .first_mismatch_idx(a_idx));

   mismatch_monitor #(.CNT_W(16), .WARMUP(3), .THRESHOLD(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid), .equal(equal),
      .active(b_active), .done(b_done), .fail(b_fail), .sample_count(b_smp),
      .mismatch_count(b_mis), .first_mismatch_vld(b_fmv), .first_mismatch_idx(b_idx));

   mismatch_monitor #(.CNT_W(4), .WARMUP(3), .THRESHOLD(15)) dut_c (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid), .equal(equal),
      .active(c_active), .done(c_done), .fail(c_fail), .sample_count(c_smp),
      .mismatch_count(c_mis), .first_mismatch_vld(c_fmv), .first_mismatch_idx(c_idx));

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic tick(input logic st, input logic sp, input logic v, input logic e);
      start = st;
      stop  = sp;
      valid = v;
      equal = e;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; valid = 1'b0; equal = 1'b0;
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      rst = 1'b0;
      chk("rst_active", a_active, 0);
      chk("rst_done", a_done, 0);
      chk("rst_fail", a_fail, 0);
      chk("rst_smp", a_smp, 0);
      chk("rst_mis", a_mis, 0);
      chk("rst_fmv", a_fmv, 0);
      chk("rst_idx", a_idx, 0);

      // basic pass
      tick(1, 0, 0, 0);
      chk("basic_active", a_active, 1);
      repeat (3) tick(0, 0, 0, 0);
      repeat (10) tick(0, 0, 1, 1);
      chk("basic_smp_pre", a_smp, 10);
      tick(0, 1, 0, 0);
      chk("basic_done", a_done, 1);
      chk("basic_inactive", a_active, 0);
      chk("basic_smp", a_smp, 10);
      chk("basic_mis", a_mis, 0);
      chk("basic_fmv", a_fmv, 0);

      // warm-up masking: mismatches during warm-up must not count
      tick(1, 0, 0, 0);
      repeat (3) tick(0, 0, 1, 0);
      chk("wu_mis", a_mis, 0);
      chk("wu_smp", a_smp, 0);
      chk("wu_fail", a_fail, 0);
      chk("wu_active", a_active, 1);
      repeat (2) tick(0, 0, 1, 1);
      chk("wu_first_counted", a_smp, 2);
      tick(0, 1, 0, 0);

      // first index and threshold, pattern 1,1,0,1,0,0
      tick(1, 0, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
      tick(0, 0, 1, 1);
      tick(0, 0, 1, 1);
      tick(0, 0, 1, 0);
      chk("t1_fail", a_fail, 1);
      chk("t1_mis", a_mis, 1);
      chk("t1_idx", a_idx, IDX_EN ? 2 : 0);
      tick(0, 0, 1, 1);
      tick(0, 0, 1, 0);
      chk("t2_nofail", b_fail, 0);
      chk("t2_mis_pre", b_mis, 2);
      tick(0, 0, 1, 0);
      chk("t2_fail", b_fail, 1);
      chk("t2_inactive", b_active, 0);
      chk("t2_smp", b_smp, 6);
      chk("t2_mis", b_mis, 3);
      chk("t2_fmv", b_fmv, 1);
      chk("t2_idx", b_idx, IDX_EN ? 2 : 0);

      // restart from FAIL
      tick(1, 0, 0, 0);
      chk("restart_fail", b_fail, 0);
      chk("restart_active", b_active, 1);
      chk("restart_smp", b_smp, 0);
      chk("restart_mis", b_mis, 0);
      chk("restart_fmv", b_fmv, 0);

      // valid gaps: mismatches only on invalid cycles
      repeat (3) tick(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) tick(0, 0, (i % 2 == 0), (i % 2 == 0));
      chk("gap_smp", b_smp, 4);
      chk("gap_mis", b_mis, 0);

      // stop coincident with a mismatch
      tick(0, 1, 1, 0);
      chk("stopmis_done", a_done, 1);
      chk("stopmis_fail", a_fail, 0);
      chk("stopmis_mis", a_mis, 0);
      chk("stopmis_smp", a_smp, 4);

      // saturation on the 4-bit instance
      tick(1, 0, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
      repeat (20) tick(0, 0, 1, 1);
      chk("sat_smp", c_smp, 15);
      chk("sat_nofail", c_fail, 0);
      tick(0, 0, 1, 0);
      chk("sat_mis1", c_mis, 1);
      chk("sat_idx", c_idx, IDX_EN ? 15 : 0);
      repeat (13) tick(0, 0, 1, 0);
      chk("sat_mis14", c_mis, 14);
      chk("sat_fail14", c_fail, 0);
      tick(0, 0, 1, 0);
      chk("sat_fail15", c_fail, 1);
      chk("sat_mis15", c_mis, 15);
      repeat (5) tick(0, 0, 1, 0);
      chk("sat_mis_hold", c_mis, 15);
      chk("sat_smp_hold", c_smp, 15);

      // reset in MONITOR overrides start and stop
      tick(0, 1, 0, 0);
      tick(1, 0, 0, 0);
      repeat (3) tick(0, 0, 0, 0);
      tick(0, 0, 1, 0);
      tick(0, 0, 1, 0);
      chk("mrst_pre_mis", c_mis, 2);
      chk("mrst_pre_active", c_active, 1);
      rst = 1'b1;
      tick(1, 1, 1, 0);
      rst = 1'b0;
      chk("mrst_active", c_active, 0);
      chk("mrst_done", c_done, 0);
      chk("mrst_fail", c_fail, 0);
      chk("mrst_smp", c_smp, 0);
      chk("mrst_mis", c_mis, 0);
      chk("mrst_fmv", c_fmv, 0);
      chk("mrst_idx", c_idx, 0);
      tick(0, 1, 0, 0);
      chk("idle_stop_ignored", c_done, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mismatch_monitor.md
# mismatch_monitor

Scoreboard stage that sits directly downstream of the 3-cycle delay-and-compare block and consumes its per-cycle `equal` result. It masks the compare pipeline's post-reset/post-start warm-up, counts compared samples and mismatches, records the index of the first mismatch, and raises a sticky failure once a run of consecutive mismatches reaches a threshold. Testbenches and on-chip self-check logic read its status outputs.

## Interface
- `CNT_W`, 16, width of all counters and the index output.
- `WARMUP`, 3, clock cycles ignored after leaving IDLE. This equals the compare pipeline depth. 0 means no warm-up.
- `THRESHOLD`, 1, consecutive valid mismatches that trigger FAIL. Legal range is 1 ≤ THRESHOLD < 2^CNT_W.

- `clk`, in, 1, clock.
- `rst`, in, 1, synchronous, active-high reset.
- `start`, in, 1, pulse that begins a monitoring session.
- `stop`, in, 1, pulse that ends a session.
- `valid`, in, 1, qualifies `equal` this cycle.
- `equal`, in, 1, compare result from the upstream comparator.
- `active`, out, 1, high in WARMUP or MONITOR.
- `done`, out, 1, session ended cleanly by `stop`.
- `fail`, out, 1, sticky threshold violation.
- `sample_count`, out, CNT_W, valid samples compared.
- `mismatch_count`, out, CNT_W, valid samples with `equal`=0.
- `first_mismatch_vld`, out, 1, a mismatch has been recorded this session.
- `first_mismatch_idx`, out, CNT_W, `sample_count` value at the first mismatch.

## Operation
- States: IDLE, WARMUP, MONITOR, DONE, FAIL. All outputs are registered.
- Reset: state goes to IDLE. Every output and internal counter goes to 0.
- IDLE: on `start`, clear all counters and flags, then go to WARMUP. If WARMUP=0, go directly to MONITOR.
- WARMUP:
  - A cycle counter runs from 0 to WARMUP-1, then the state moves to MONITOR.
  - `valid` and `equal` are ignored.
  - `stop` moves to DONE.
- MONITOR, per cycle, in this priority order:
  1. `stop`=1: go to DONE. That cycle's sample is not counted.
  2. `valid`=1: `sample_count`++.
  3. If `equal`=0 in that valid cycle:
     - `mismatch_count`++ and the consecutive-mismatch counter ++.
     - If `first_mismatch_vld`=0, latch `first_mismatch_idx` = pre-increment `sample_count` and set `first_mismatch_vld`.
     - If the consecutive counter reaches THRESHOLD, go to FAIL.
  4. If `equal`=1 in that valid cycle: the consecutive counter clears to 0.
  5. `valid`=0: all counters hold.
- DONE and FAIL:
  - Counters hold.
  - `start` performs the same clear-and-restart as from IDLE.
  - `stop` is ignored.
- `start` is ignored in WARMUP and MONITOR.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Once `sample_count` saturates, `first_mismatch_idx` latches the saturated value.

## Timing
- Single-cycle latency: a sample presented in cycle N is reflected on the counters in cycle N+1.
- `fail` rises in cycle N+1 after the threshold-reaching mismatch in cycle N. That mismatch is included in `mismatch_count`.
- `start` at cycle S:
  - `active`=1 from S+1.
  - The first sample counted is at cycle S+1+WARMUP.
- `done` and `active`=0 are visible the cycle after `stop`.
- Simultaneous `stop` and a mismatch in MONITOR: stop wins. Nothing is counted and `fail` does not rise.
- Simultaneous `start` and `stop`: `stop` governs in WARMUP/MONITOR. `start` governs in IDLE/DONE/FAIL.
- `rst` mid-session returns the block to IDLE with all outputs 0 on the next cycle. It overrides `start` and `stop`.

## Configuration
- Macro: `MISMATCH_MONITOR_FIRST_IDX_EN`.
- Defined: the `first_mismatch_idx` register is implemented as described above.
- Undefined:
  - `first_mismatch_idx` is driven constant 0 and no register is inferred.
  - `first_mismatch_vld` and all other behaviour are unchanged.

## Test plan
- Basic pass: rst, `start`, 3 warm-up cycles, 10 valid cycles with `equal`=1, then `stop`. Expect `done`=1, `sample_count`=10, `mismatch_count`=0, `first_mismatch_vld`=0.
- Warm-up masking: `equal`=0 during the 3 warm-up cycles, then equal samples. Expect `mismatch_count`=0 and `fail`=0.
- First-index and threshold: THRESHOLD=2.
  - `equal` pattern 1,1,0,1,0,0 on valid cycles.
  - Expect `first_mismatch_idx`=2 and `mismatch_count`=3.
  - `fail` rises the cycle after the 6th sample. `sample_count`=6.
- Valid gaps: alternate `valid`=1/0 with `equal`=0 only on `valid`=0 cycles for 8 cycles. Expect `sample_count`=4 and `mismatch_count`=0.
- Saturation: CNT_W=4 with 20 valid mismatches and THRESHOLD=15. Expect `fail` after the 15th, and counters holding at 15 with no wrap.
- Boundary events:
  - `stop` coincident with a mismatch: not counted, and `done` is set.
  - `rst` asserted in MONITOR: all outputs 0 next cycle.
  - `start` from FAIL: counters cleared and WARMUP re-entered.
